// File: rtl/rvv_alu_pkg.sv
// -----------------------------------------------------------------------------
// rvv_alu_pkg
// Shared definitions for the vector ALU result path.
//   ALU_RES_t        : one result record {tag, data, sat} at the default widths
//   ALU_*            : default parameters of rvv_backend_alu_result_pipe
//   alu_res_w()      : packed width of a {tag, data, sat} record for any widths
// -----------------------------------------------------------------------------
package rvv_alu_pkg;

    localparam int ALU_NUM_SRC = 4;
    localparam int ALU_DATA_W  = 128;
    localparam int ALU_TAG_W   = 4;
    localparam int ALU_DEPTH   = 2;
    localparam int ALU_SAT_W   = ALU_DATA_W / 8;
    localparam int ALU_RES_W   = ALU_TAG_W + ALU_DATA_W + ALU_SAT_W;

    typedef struct packed {
        logic [ALU_TAG_W-1:0]  tag;
        logic [ALU_DATA_W-1:0] data;
        logic [ALU_SAT_W-1:0]  sat;
    } ALU_RES_t;

    // Records are carried flat as {tag, data, sat}; one saturation bit per byte.
    function automatic int alu_res_w(input int tag_w, input int data_w);
        return tag_w + data_w + data_w / 8;
    endfunction

endpackage

// File: rtl/rvv_backend_alu_res_fifo.sv
// -----------------------------------------------------------------------------
// rvv_backend_alu_res_fifo
// In-order FIFO with two write ports and one read port.
//   clk, rst            : clock, synchronous active-high reset
//   wr0_en / wr0_data   : older write of the cycle
//   wr1_en / wr1_data   : younger write of the cycle (lands after wr0)
//   rd_en               : pop the head (only when cnt != 0)
//   head                : current head entry
//   cnt                 : occupancy, 0..DEPTH
//   free                : slots usable this cycle, counting a same-cycle pop
// The caller never writes more entries than `free` reports.
// -----------------------------------------------------------------------------
module rvv_backend_alu_res_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr0_en,
    input  logic [WIDTH-1:0] wr0_data,
    input  logic             wr1_en,
    input  logic [WIDTH-1:0] wr1_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] free
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Compact the two write ports: whichever is present first takes wr_ptr.
    logic             first_en;
    logic [WIDTH-1:0] first_data;
    logic             second_en;

    assign first_en   = wr0_en | wr1_en;
    assign first_data = wr0_en ? wr0_data : wr1_data;
    assign second_en  = wr0_en & wr1_en;

    assign head = mem[rd_ptr];
    assign free = CNT_W'(DEPTH) - cnt + CNT_W'(rd_en);

    always_ff @(posedge clk) begin
        if (first_en)
            mem[wr_ptr] <= first_data;
        if (second_en)
            mem[ptr_inc(wr_ptr)] <= wr1_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (second_en)
                wr_ptr <= ptr_inc(ptr_inc(wr_ptr));
            else if (first_en)
                wr_ptr <= ptr_inc(wr_ptr);
            if (rd_en)
                rd_ptr <= ptr_inc(rd_ptr);
            cnt <= cnt + CNT_W'(first_en) + CNT_W'(second_en) - CNT_W'(rd_en);
        end
    end

endmodule

// File: rtl/rvv_backend_alu_result_pipe.sv
// -----------------------------------------------------------------------------
// rvv_backend_alu_result_pipe
// Stages ALU results from NUM_SRC p0 sources towards the ROB, in order.
//   clk, rst                      : clock, synchronous active-high reset
//   src_valid/2cycle/tag/data/sat : per-source results (src_valid one-hot or 0)
//   pop_rs                        : the selected source is accepted this cycle
//   p1_valid/tag/data/sat         : p1 stage contents to the external p1 unit
//   p1_res_data/p1_res_sat        : combinational result of the p1 unit
//   res_valid/tag/data/sat        : result to the ROB
//   res_ready                     : ROB accepts the result
//   busy                          : FIFO non-empty or p1 occupied
//
// Handshake: a transfer happens on every cycle where the valid and its
// matching ready/pop are both high (res_valid & res_ready towards the ROB,
// src_valid & pop_rs from the sources). res_valid never depends on res_ready;
// pop_rs may. Once res_valid is high without res_ready, res_* hold their
// values until the transfer completes.
//
// Age order is FIFO (oldest) > p1 stage > current p0 source; the head is
// always the oldest live item, and same-cycle FIFO writes put p1 before p0.
// -----------------------------------------------------------------------------
module rvv_backend_alu_result_pipe
    import rvv_alu_pkg::*;
#(
    parameter int NUM_SRC = ALU_NUM_SRC,
    parameter int DATA_W  = ALU_DATA_W,
    parameter int TAG_W   = ALU_TAG_W,
    parameter int DEPTH   = ALU_DEPTH,
    localparam int SAT_W  = DATA_W / 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC-1:0]        src_valid,
    input  logic [NUM_SRC-1:0]        src_2cycle,
    input  logic [NUM_SRC*TAG_W-1:0]  src_tag,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    input  logic [NUM_SRC*SAT_W-1:0]  src_sat,
    output logic                      pop_rs,
    output logic                      p1_valid,
    output logic [TAG_W-1:0]          p1_tag,
    output logic [DATA_W-1:0]         p1_data,
    output logic [SAT_W-1:0]          p1_sat,
    input  logic [DATA_W-1:0]         p1_res_data,
    input  logic [SAT_W-1:0]          p1_res_sat,
    output logic                      res_valid,
    output logic [TAG_W-1:0]          res_tag,
    output logic [DATA_W-1:0]         res_data,
    output logic [SAT_W-1:0]          res_sat,
    input  logic                      res_ready,
    output logic                      busy
);

    localparam int RES_W = alu_res_w(TAG_W, DATA_W);
    localparam int SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    // ---------------- source selection (lowest index wins) ----------------
    logic [SEL_W-1:0] sel_idx;
    logic             any_valid;
    logic             sel_2c;
    logic [RES_W-1:0] sel_res;

    always_comb begin
        sel_idx   = '0;
        any_valid = 1'b0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (src_valid[i]) begin
                sel_idx   = SEL_W'(i);
                any_valid = 1'b1;
            end
        end
    end

    assign sel_2c  = src_2cycle[sel_idx];
    assign sel_res = {src_tag[sel_idx*TAG_W +: TAG_W],
                      src_data[sel_idx*DATA_W +: DATA_W],
                      src_sat[sel_idx*SAT_W +: SAT_W]};

    // ---------------- p1 stage ----------------
    logic             p1_valid_q;
    logic [RES_W-1:0] p1_q;
    logic [RES_W-1:0] p1_res;

    assign p1_tag  = p1_q[RES_W-1 -: TAG_W];
    assign p1_data = p1_q[SAT_W +: DATA_W];
    assign p1_sat  = p1_q[SAT_W-1:0];
    assign p1_res  = {p1_tag, p1_res_data, p1_res_sat};

    // ---------------- FIFO ----------------
    logic             fifo_wr0;
    logic             fifo_wr1;
    logic             fifo_rd;
    logic [RES_W-1:0] fifo_head;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] free;

    rvv_backend_alu_res_fifo #(
        .WIDTH (RES_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr0_en   (fifo_wr0),
        .wr0_data (p1_res),
        .wr1_en   (fifo_wr1),
        .wr1_data (sel_res),
        .rd_en    (fifo_rd),
        .head     (fifo_head),
        .cnt      (cnt),
        .free     (free)
    );

    // ---------------- head selection and accept ----------------
    logic fifo_nonempty;
    logic offer;
    logic head_is_fifo;
    logic head_is_p1;
    logic head_is_p0;
    logic deq;
    logic p1_drain;
    logic p1_wr;
    logic p1_ok;
    logic accept_2c;
    logic accept_1c;

    assign fifo_nonempty = (cnt != '0);
    assign offer         = any_valid && !rst;

    // A p0 head only arises with an empty pipe, where a single-cycle uop is
    // always accepted; this keeps res_valid free of any res_ready path.
    assign head_is_fifo = !rst && fifo_nonempty;
    assign head_is_p1   = !rst && !fifo_nonempty && p1_valid_q;
    assign head_is_p0   = offer && !fifo_nonempty && !p1_valid_q && !sel_2c;

    assign res_valid = head_is_fifo || head_is_p1 || head_is_p0;
    assign {res_tag, res_data, res_sat} = head_is_fifo ? fifo_head :
                                          head_is_p1   ? p1_res    : sel_res;

    assign deq     = res_valid && res_ready;
    assign fifo_rd = deq && head_is_fifo;

    // p1 leaves either straight to the ROB or into a free FIFO slot.
    assign p1_drain = p1_valid_q && !rst && ((head_is_p1 && deq) || (free != '0));
    assign p1_wr    = p1_drain && !(head_is_p1 && deq);
    assign p1_ok    = !p1_valid_q || p1_drain;

    assign accept_2c = offer && sel_2c && p1_ok;
    assign accept_1c = offer && !sel_2c && p1_ok &&
                       ((free > CNT_W'(p1_wr)) || (head_is_p0 && deq));

    assign pop_rs   = accept_2c || accept_1c;
    assign fifo_wr0 = p1_wr;
    assign fifo_wr1 = accept_1c && !(head_is_p0 && deq);

    always_ff @(posedge clk) begin
        if (rst)
            p1_valid_q <= 1'b0;
        else if (accept_2c)
            p1_valid_q <= 1'b1;
        else if (p1_drain)
            p1_valid_q <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (accept_2c)
            p1_q <= sel_res;
    end

    // Status outputs read as idle for the whole reset cycle.
    assign p1_valid = p1_valid_q && !rst;
    assign busy     = !rst && (fifo_nonempty || p1_valid_q);

endmodule

// File: tb/tb_rvv_backend_alu_result_pipe.sv
module tb_rvv_backend_alu_result_pipe;
    import rvv_alu_pkg::*;

    localparam int NUM_SRC = 4;
    localparam int DATA_W  = 128;
    localparam int TAG_W   = 4;
    localparam int DEPTH   = 2;
    localparam int SAT_W   = DATA_W / 8;
    localparam int RES_W   = $bits(ALU_RES_t);

    logic                      clk;
    logic                      rst;
    logic [NUM_SRC-1:0]        src_valid;
    logic [NUM_SRC-1:0]        src_2cycle;
    logic [NUM_SRC*TAG_W-1:0]  src_tag;
    logic [NUM_SRC*DATA_W-1:0] src_data;
    logic [NUM_SRC*SAT_W-1:0]  src_sat;
    logic                      pop_rs;
    logic                      p1_valid;
    logic [TAG_W-1:0]          p1_tag;
    logic [DATA_W-1:0]         p1_data;
    logic [SAT_W-1:0]          p1_sat;
    logic [DATA_W-1:0]         p1_res_data;
    logic [SAT_W-1:0]          p1_res_sat;
    logic                      res_valid;
    logic [TAG_W-1:0]          res_tag;
    logic [DATA_W-1:0]         res_data;
    logic [SAT_W-1:0]          res_sat;
    logic                      res_ready;
    logic                      busy;

    rvv_backend_alu_result_pipe #(
        .NUM_SRC (NUM_SRC),
        .DATA_W  (DATA_W),
        .TAG_W   (TAG_W),
        .DEPTH   (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .src_valid   (src_valid),
        .src_2cycle  (src_2cycle),
        .src_tag     (src_tag),
        .src_data    (src_data),
        .src_sat     (src_sat),
        .pop_rs      (pop_rs),
        .p1_valid    (p1_valid),
        .p1_tag      (p1_tag),
        .p1_data     (p1_data),
        .p1_sat      (p1_sat),
        .p1_res_data (p1_res_data),
        .p1_res_sat  (p1_res_sat),
        .res_valid   (res_valid),
        .res_tag     (res_tag),
        .res_data    (res_data),
        .res_sat     (res_sat),
        .res_ready   (res_ready),
        .busy        (busy)
    );

    // p1 execution unit model: data + 1, inverted saturation flags.
    assign p1_res_data = p1_data + DATA_W'(1);
    assign p1_res_sat  = ~p1_sat;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sources must never offer more than one result at a time.
    always @(negedge clk) begin
        if (rst === 1'b0)
            assert ($countones(src_valid) <= 1)
            else $error("src_valid not one-hot: %b", src_valid);
    end

    // ---------------- vectors ----------------
    typedef struct {
        bit               rst;
        int               src;     // -1: no source valid
        bit               two;
        logic [TAG_W-1:0] tag;
        logic [DATA_W-1:0] data;   // 0: use data_of(tag)
        bit               rdy;
        bit               e_pop;
        bit               e_rv;
        logic [TAG_W-1:0] e_tag;
        bit               e_busy;
        bit               e_p1v;
    } vec_t;

    vec_t vecs[$];
    logic [RES_W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    function automatic logic [DATA_W-1:0] data_of(input logic [TAG_W-1:0] t);
        logic [DATA_W-1:0] d;
        for (int k = 0; k < DATA_W / 16; k++)
            d[k*16 +: 16] = {8'hA5, 4'h0, t};
        return d;
    endfunction

    function automatic logic [SAT_W-1:0] sat_of(input logic [TAG_W-1:0] t);
        return {(SAT_W / TAG_W){t}};
    endfunction

    function automatic vec_t mk(input bit r, input int s, input bit two, input int tag,
                                input logic [DATA_W-1:0] d, input bit rdy, input bit ep,
                                input bit erv, input int etag, input bit eb, input bit ep1);
        vec_t v;
        v.rst = r; v.src = s; v.two = two; v.tag = TAG_W'(tag); v.data = d;
        v.rdy = rdy; v.e_pop = ep; v.e_rv = erv; v.e_tag = TAG_W'(etag);
        v.e_busy = eb; v.e_p1v = ep1;
        return v;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [RES_W-1:0] act,
                         input logic [RES_W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic sb_pop();
        logic [RES_W-1:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected actual_tag=%0h required=none at %0t", res_tag, $time);
        end else begin
            e = exp_q.pop_front();
            check("sb_result", {res_tag, res_data, res_sat}, e);
        end
    endtask

    // ---------------- driver ----------------
    // Inputs change just after posedge; outputs are checked at negedge.
    task automatic drive(input vec_t v);
        logic [DATA_W-1:0] d;
        ALU_RES_t e;
        d = (v.data != '0) ? v.data : data_of(v.tag);
        rst        = v.rst;
        res_ready  = v.rdy;
        src_valid  = '0;
        src_2cycle = '0;
        src_tag    = '0;
        src_data   = '0;
        src_sat    = '0;
        if (v.src >= 0) begin
            src_valid[v.src]                 = 1'b1;
            src_2cycle[v.src]                = v.two;
            src_tag[v.src*TAG_W +: TAG_W]    = v.tag;
            src_data[v.src*DATA_W +: DATA_W] = d;
            src_sat[v.src*SAT_W +: SAT_W]    = sat_of(v.tag);
        end
        @(negedge clk);
        check("pop_rs", RES_W'(pop_rs), RES_W'(v.e_pop));
        check("res_valid", RES_W'(res_valid), RES_W'(v.e_rv));
        if (v.e_rv)
            check("res_tag", RES_W'(res_tag), RES_W'(v.e_tag));
        check("busy", RES_W'(busy), RES_W'(v.e_busy));
        check("p1_valid", RES_W'(p1_valid), RES_W'(v.e_p1v));
        if (v.e_pop) begin
            e.tag  = v.tag;
            e.data = v.two ? d + DATA_W'(1) : d;
            e.sat  = v.two ? ~sat_of(v.tag) : sat_of(v.tag);
            exp_q.push_back(e);
        end
        if (res_valid && res_ready)
            sb_pop();
        if (v.rst)
            exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    // ---------------- test ----------------
    initial begin
        rst = 1'b1; res_ready = 1'b0;
        src_valid = '0; src_2cycle = '0; src_tag = '0; src_data = '0; src_sat = '0;

        //              rst src 2c tag data       rdy  pop rv etag busy p1v
        // reset state (offered uop must be ignored)
        vecs.push_back(mk(1,  0, 0, 1, '0,         1,   0, 0, 0, 0, 0));
        vecs.push_back(mk(1,  0, 0, 1, '0,         1,   0, 0, 0, 0, 0));
        // empty pipe bypass
        vecs.push_back(mk(0,  1, 0, 3, '0,         1,   1, 1, 3, 0, 0));
        // 2-cycle uop, p1 result 0x1234
        vecs.push_back(mk(0,  2, 1, 5, 128'h1233,  1,   1, 0, 0, 0, 0));
        vecs.push_back(mk(0, -1, 0, 0, '0,         1,   0, 1, 5, 1, 1));
        vecs.push_back(mk(0, -1, 0, 0, '0,         1,   0, 0, 0, 0, 0));
        // mixed ordering: 2-cycle tag 7 then single-cycle tag 8
        vecs.push_back(mk(0,  0, 1, 7, '0,         1,   1, 0, 0, 0, 0));
        vecs.push_back(mk(0,  3, 0, 8, '0,         1,   1, 1, 7, 1, 1));
        vecs.push_back(mk(0, -1, 0, 0, '0,         1,   0, 1, 8, 1, 0));
        vecs.push_back(mk(0, -1, 0, 0, '0,         1,   0, 0, 0, 0, 0));
        // backpressure fill, tags 0..3
        vecs.push_back(mk(0,  0, 0, 0, '0,         0,   1, 1, 0, 0, 0));
        vecs.push_back(mk(0,  1, 0, 1, '0,         0,   1, 1, 0, 1, 0));
        vecs.push_back(mk(0,  2, 0, 2, '0,         0,   0, 1, 0, 1, 0));
        vecs.push_back(mk(0,  2, 0, 2, '0,         0,   0, 1, 0, 1, 0));
        vecs.push_back(mk(0,  2, 0, 2, '0,         1,   1, 1, 0, 1, 0));
        vecs.push_back(mk(0,  3, 0, 3, '0,         1,   1, 1, 1, 1, 0));
        vecs.push_back(mk(0, -1, 0, 0, '0,         1,   0, 1, 2, 1, 0));
        vecs.push_back(mk(0, -1, 0, 0, '0,         1,   0, 1, 3, 1, 0));
        vecs.push_back(mk(0, -1, 0, 0, '0,         1,   0, 0, 0, 0, 0));
        // fill, then full rate through a full FIFO (pointer wrap)
        vecs.push_back(mk(0,  0, 0, 4, '0,         0,   1, 1, 4, 0, 0));
        vecs.push_back(mk(0,  1, 0, 5, '0,         0,   1, 1, 4, 1, 0));
        vecs.push_back(mk(0,  2, 0, 6, '0,         1,   1, 1, 4, 1, 0));
        vecs.push_back(mk(0,  3, 0, 7, '0,         1,   1, 1, 5, 1, 0));
        vecs.push_back(mk(0,  0, 0, 8, '0,         1,   1, 1, 6, 1, 0));
        vecs.push_back(mk(0,  1, 0, 9, '0,         1,   1, 1, 7, 1, 0));
        vecs.push_back(mk(0, -1, 0, 0, '0,         1,   0, 1, 8, 1, 0));
        vecs.push_back(mk(0, -1, 0, 0, '0,         1,   0, 1, 9, 1, 0));
        vecs.push_back(mk(0, -1, 0, 0, '0,         1,   0, 0, 0, 0, 0));
        // p1 plus FIFO under backpressure: DEPTH + 1 absorbed
        vecs.push_back(mk(0,  0, 1, 10, '0,        0,   1, 0, 0, 0, 0));
        vecs.push_back(mk(0,  1, 0, 11, '0,        0,   1, 1, 10, 1, 1));
        vecs.push_back(mk(0,  2, 1, 12, '0,        0,   1, 1, 10, 1, 0));
        vecs.push_back(mk(0,  3, 0, 13, '0,        0,   0, 1, 10, 1, 1));
        vecs.push_back(mk(0,  3, 0, 13, '0,        1,   0, 1, 10, 1, 1));
        vecs.push_back(mk(0,  3, 0, 13, '0,        1,   1, 1, 11, 1, 0));
        vecs.push_back(mk(0, -1, 0, 0, '0,         1,   0, 1, 12, 1, 0));
        vecs.push_back(mk(0, -1, 0, 0, '0,         1,   0, 1, 13, 1, 0));
        vecs.push_back(mk(0, -1, 0, 0, '0,         1,   0, 0, 0, 0, 0));
        // mid-operation reset with cnt = 2 and p1 occupied
        vecs.push_back(mk(0,  0, 1, 1, '0,         0,   1, 0, 0, 0, 0));
        vecs.push_back(mk(0,  1, 0, 2, '0,         0,   1, 1, 1, 1, 1));
        vecs.push_back(mk(0,  2, 1, 3, '0,         0,   1, 1, 1, 1, 0));
        vecs.push_back(mk(1, -1, 0, 0, '0,         0,   0, 0, 0, 0, 0));
        vecs.push_back(mk(0,  3, 0, 4, '0,         1,   1, 1, 4, 0, 0));
        vecs.push_back(mk(0, -1, 0, 0, '0,         1,   0, 0, 0, 0, 0));

        foreach (vecs[i])
            drive(vecs[i]);

        // Stall stability: the head must not change while the ROB stalls.
        drive(mk(0, 1, 0, 9, '0, 0, 1, 1, 9, 0, 0));
        for (int k = 0; k < 3; k++) begin
            drive(mk(0, -1, 0, 0, '0, 0, 0, 1, 9, 1, 0));
            check("stall_data", RES_W'(res_data), RES_W'(data_of(4'd9)));
            check("stall_sat", RES_W'(res_sat), RES_W'(sat_of(4'd9)));
        end
        drive(mk(0, -1, 0, 0, '0, 1, 0, 1, 9, 1, 0));
        drive(mk(0, -1, 0, 0, '0, 1, 0, 0, 0, 0, 0));

        // Everything accepted must have been delivered.
        check("sb_leftover", RES_W'(exp_q.size()), RES_W'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
